// File: rtl/serial_addsub_unit.sv
// serial_addsub_unit: digit-serial adder/subtractor.
//   Accepts two WIDTH-bit operands and a mode (0 = A+B, 1 = A-B) in IDLE.
//   It processes DIGIT bits per cycle, LSB digit first, for WIDTH/DIGIT cycles.
//   It then presents the result in DONE until the consumer accepts it.
// Parameters: WIDTH (operand/result width), DIGIT (bits per cycle, divides WIDTH)
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   in_valid, in_ready operand handshake (in_ready high only in IDLE)
//   a, b, mode         operands and operation select
//   out_valid, out_ready result handshake (out_valid high only in DONE)
//   result, cout, ovf, zero  result, carry out, signed overflow, result == 0
// Configuration macro: ADDSUB_SAT_EN enables signed saturation of an overflowed result.
module serial_addsub_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             mode_r;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT:0]   sum;
  logic             c_msb;
  logic             ovf_c;
  logic             last;
  logic [WIDTH-1:0] res_full;
  logic [WIDTH-1:0] res_fin;

  // One digit of the ripple: subtraction is A + ~B + 1, with the +1 seeded into carry.
  always_comb begin
    a_dig    = a_r[int'(cnt)*DIGIT +: DIGIT];
    b_dig    = b_r[int'(cnt)*DIGIT +: DIGIT] ^ {DIGIT{mode_r}};
    sum      = {1'b0, a_dig} + {1'b0, b_dig} + (DIGIT+1)'(carry);
    // Carry into the digit's top bit recovered from its sum bit (s = a ^ b ^ cin).
    c_msb    = sum[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];
    ovf_c    = c_msb ^ sum[DIGIT];
    last     = (cnt == CW'(NDIG - 1));
    res_full = result;
    res_full[int'(cnt)*DIGIT +: DIGIT] = sum[DIGIT-1:0];
    res_fin  = res_full;
`ifdef ADDSUB_SAT_EN
    // On overflow A and effective B share a sign; that sign picks the rail.
    if (last && ovf_c) begin
      res_fin = a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      mode_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            mode_r   <= mode;
            carry    <= mode;
            cnt      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          result <= res_fin;
          carry  <= sum[DIGIT];
          if (last) begin
            cnt       <= '0;
            cout      <= sum[DIGIT];
            ovf       <= ovf_c;
            zero      <= (res_fin == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          // Always pass through IDLE so a new request waits one cycle.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Testbench for serial_addsub_unit (WIDTH=16, DIGIT=4): directed vector table,
// multi-cycle corner sequences and randomized transactions against an arithmetic model.
module tb_serial_addsub_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        cout;
  logic        ovf;
  logic        zero;

  int passed = 0;
  int total  = 0;

  serial_addsub_unit #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic        vm;
    logic [15:0] er;
    logic        ec;
    logic        eo;
    logic        ez;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference computed from signed/unsigned integer arithmetic.
  function automatic void model(input logic [15:0] ma, input logic [15:0] mb, input logic mm,
                                output logic [15:0] r, output logic co, output logic ov,
                                output logic z);
    int ua, ub, sa, sb, us, ss;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (mm) begin
      us = ua - ub;
      ss = sa - sb;
      co = (ua >= ub);
    end else begin
      us = ua + ub;
      ss = sa + sb;
      co = (us > 65535);
    end
    ov = (ss > 32767) || (ss < -32768);
    r  = 16'(us);
`ifdef ADDSUB_SAT_EN
    if (ov) r = (ss > 0) ? 16'h7FFF : 16'h8000;
`endif
    z = (r == 16'h0000);
  endfunction

  // Issue one transaction, check latency, hold DONE for 'stall' cycles, then handshake.
  task automatic run_txn(input logic [15:0] ta, input logic [15:0] tb_op, input logic tm,
                         input int stall, output logic [15:0] r, output logic co,
                         output logic ov, output logic z);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("idle_wait", 32'(in_ready), 32'd1);
    @(negedge clk);
    a = ta; b = tb_op; mode = tm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); mode = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("latency", 32'(lat), 32'd4);
    r = result; co = cout; ov = ovf; z = zero;
    repeat (stall) @(posedge clk);
    #1;
    check("hold_result", 32'(result), 32'(r));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ready_after_hs", 32'(in_ready), 32'd1);
    check("valid_after_hs", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[5];
    logic [15:0] r, er;
    logic co, ov, z, eco, eov, ez;
    int acc_cyc[$];
    logic [15:0] exp_q[$];
    int cyc, accepts;

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
`ifdef ADDSUB_SAT_EN
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0};
`else
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
`endif

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; mode = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", {29'd0, cout, ovf, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i].va, vecs[i].vb, vecs[i].vm, 0, r, co, ov, z);
      check($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].er));
      check($sformatf("vec%0d_cout", i), 32'(co), 32'(vecs[i].ec));
      check($sformatf("vec%0d_ovf", i), 32'(ov), 32'(vecs[i].eo));
      check($sformatf("vec%0d_zero", i), 32'(z), 32'(vecs[i].ez));
    end

    // Stall in DONE with a competing request; it must not be captured.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("stall_valid_rise", 32'(out_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a = 16'hAAAA; b = 16'h5555; mode = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      check("stall_result", 32'(result), 32'h3333);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_ready_next", 32'(in_ready), 32'd1);
    check("stall_valid_drop", 32'(out_valid), 32'd0);
    in_valid = 1'b0; out_ready = 1'b0;

    // Reset in the middle of BUSY.
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_flags", {28'd0, out_valid, cout, ovf, zero}, 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(16'h0001, 16'h0001, 1'b0, 0, r, co, ov, z);
    check("post_rst_result", 32'(r), 32'h0002);

    // Randomized transactions against the model.
    for (int i = 0; i < 20; i++) begin
      logic [15:0] ra, rb;
      logic rm;
      ra = 16'($urandom); rb = 16'($urandom); rm = 1'($urandom);
      if (i == 0) begin ra = 16'h8000; rb = 16'h8000; rm = 1'b0; end
      if (i == 1) begin ra = 16'h0000; rb = 16'h0000; rm = 1'b1; end
      model(ra, rb, rm, er, eco, eov, ez);
      run_txn(ra, rb, rm, int'($urandom_range(0, 2)), r, co, ov, z);
      check("rnd_result", 32'(r), 32'(er));
      check("rnd_cout", 32'(co), 32'(eco));
      check("rnd_ovf", 32'(ov), 32'(eov));
      check("rnd_zero", 32'(z), 32'(ez));
    end

    // Back-to-back with in_valid held high and out_ready=1.
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    cyc = 0; accepts = 0;
    while (cyc < 60 && (accepts < 5 || exp_q.size() > 0)) begin
      if (out_valid) begin
        if (exp_q.size() > 0) check("b2b_result", 32'(result), 32'(exp_q.pop_front()));
        else check("b2b_extra_out", 32'd1, 32'd0);
      end
      if (in_ready) begin
        if (accepts < 5) begin
          a = 16'($urandom); b = 16'($urandom); mode = 1'($urandom);
          model(a, b, mode, er, eco, eov, ez);
          exp_q.push_back(er);
          acc_cyc.push_back(cyc);
          accepts++;
        end
      end
      if (accepts >= 5 && !in_ready) in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_accepts", 32'(acc_cyc.size()), 32'd5);
    check("b2b_drain", 32'(exp_q.size()), 32'd0);
    for (int i = 1; i < acc_cyc.size(); i++)
      check("b2b_period", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/serial_addsub_unit.md
SERIAL_ADDSUB_UNIT -- requirements
Module: serial_addsub_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 4, bits processed per cycle; WIDTH SHALL be a multiple of DIGIT, and DIGIT >= 1.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand request.
REQ-006 SHALL have port in_ready  output  1  unit idle, can accept operands.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port mode  input  1  0 = A+B, 1 = A-B.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  WIDTH  sum/difference.
REQ-013 SHALL have port cout  output  1  final carry out (sub: 1 = no borrow).
REQ-014 SHALL have port ovf  output  1  signed overflow.
REQ-015 SHALL have port zero  output  1  result == 0.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE: in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-017 SHALL, on an IDLE edge with in_valid=1, capture a, b and mode, initialise the carry register to mode and the digit counter to 0, and enter BUSY.
REQ-018 SHALL, in each BUSY cycle, compute digit i as a[i] + (b[i] XOR {DIGIT{mode}}) + carry, write it to result digit i, store the carry-out, and increment the counter; digits run LSB first.
REQ-019 SHALL, after WIDTH/DIGIT BUSY cycles, enter DONE, so out_valid rises exactly WIDTH/DIGIT cycles after the accepting edge.
REQ-020 SHALL, in DONE, hold result, cout, ovf and zero stable until out_ready=1, then return to IDLE on that edge.
REQ-021 SHALL NOT bypass DONE to IDLE: in_ready reasserts the cycle after the result handshake, and an in_valid coincident with that handshake is not accepted.
REQ-022 SHALL ignore in_valid, a, b and mode while BUSY or DONE.
REQ-023 SHALL set cout to the carry out of bit WIDTH-1.
REQ-024 SHALL set ovf to the XOR of the carry into bit WIDTH-1 and the carry out of bit WIDTH-1.
REQ-025 SHALL set zero from the final, post-saturation result, valid when out_valid=1.
REQ-026 SHALL, without saturation, wrap the result modulo 2^WIDTH.

Reset
REQ-027 SHALL, on any edge with rst_n=0 (including mid-BUSY or in DONE), abort the operation and force state=IDLE, with result, cout, ovf, zero, out_valid and the counter all 0.
REQ-028 SHALL drive in_ready=1 in the first cycle after the reset edge, and SHALL NOT accept in_valid on an edge where rst_n=0.

Configuration
REQ-029 SHALL, with ADDSUB_SAT_EN defined, replace an overflowed result in the DONE transition: positive overflow gives 0111..1 and negative overflow gives 1000..0, decided by the sign of A (equal to the effective sign of B on overflow); ovf and cout still report the raw condition.
REQ-030 SHALL, with ADDSUB_SAT_EN undefined, wrap the result as in REQ-026 and add no saturation logic.

Verification (WIDTH=16, DIGIT=4)
REQ-031 SHALL cover: a=0x1234, b=0x0FFF, mode=0 -> result=0x2233, cout=0, ovf=0, zero=0, out_valid exactly 4 cycles after accept.
REQ-032 SHALL cover: a=0x0005, b=0x0005, mode=1 -> result=0x0000, cout=1, zero=1, ovf=0; and a=0x0003, b=0x0005, mode=1 -> result=0xFFFE, cout=0, ovf=0.
REQ-033 SHALL cover: a=0x7FFF, b=0x0001, mode=0 -> ovf=1, cout=0, result=0x8000 (0x7FFF with ADDSUB_SAT_EN); and a=0x8000, b=0x0001, mode=1 -> ovf=1, cout=1, result=0x7FFF (0x8000 with ADDSUB_SAT_EN).
REQ-034 SHALL cover: out_ready=0 for 3 cycles in DONE while in_valid=1 with new operands -> outputs stable, in_ready=0, new operands not captured; then out_ready=1 -> in_ready=1 the next cycle.
REQ-035 SHALL cover: rst_n=0 for 1 cycle after 2 BUSY cycles -> all outputs 0 and in_ready=1 the next cycle; a fresh 0x0001+0x0001 then gives 0x0002.
REQ-036 SHALL cover: back-to-back transactions with in_valid held high -> one accept per IDLE visit, 6-cycle period at out_ready=1.
